// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Package : arb_pkg
//  Brief   : Shared constants, FSM state type and width helper for the
//            parametrised N-requester arbiter (param_arbiter).
//  Revision: 1.0 - initial release
// ============================================================================
package arb_pkg;

    // Arbitration modes selected by the MODE parameter
    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Wait counters hold values up to STARVE_LIMIT (max 15)
    localparam int c_cnt_w = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Index width for an N-entry one-hot vector (never narrower than 1 bit)
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : arb_pkg
`default_nettype wire

// File: rtl/param_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Interface : param_arbiter_if
//  Brief     : Request/grant bundle between the requesting masters and the
//              arbiter.
//              req     - level-sensitive request lines (masters -> arbiter)
//              gnt     - one-hot registered grant
//              gnt_idx - index of current owner, valid while busy=1
//              busy    - a grant is held
//              starved - per-requester wait counter saturated
//              timeout - one-cycle pulse on forced release
//  Modports  : master (requester side), slave (arbiter side)
//  Revision  : 1.0 - initial release
// ============================================================================
interface param_arbiter_if
    import arb_pkg::*;
#(
    parameter int N = 4
);
    localparam int c_iw = idx_w(N);

    logic [N-1:0]    req;
    logic [N-1:0]    gnt;
    logic [c_iw-1:0] gnt_idx;
    logic            busy;
    logic [N-1:0]    starved;
    logic            timeout;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  busy,
        input  starved,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output busy,
        output starved,
        output timeout
    );

endinterface : param_arbiter_if
`default_nettype wire

// File: rtl/arb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module  : arb_rr_pick
//  Brief   : Combinational rotating-base priority picker. Scans i_mask
//            starting at i_base and wrapping circularly; the first set bit
//            wins.
//            i_mask   - candidate vector
//            i_base   - index given highest priority
//            o_onehot - one-hot winner (zero when none)
//            o_idx    - winner index
//            o_valid  - at least one candidate present
//  Revision: 1.0 - initial release
// ============================================================================
module arb_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_mask,
    input  logic [IW-1:0] i_base,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    always_comb begin
        int pos;
        pos      = 0;
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        // Walk from the farthest offset back to the base so the nearest
        // candidate to the base is the last one written and therefore wins.
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(i_base) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (i_mask[IW'(pos)]) begin
                o_valid = 1'b1;
                o_idx   = IW'(pos);
            end
        end
        if (o_valid) begin
            o_onehot[o_idx] = 1'b1;
        end
    end

endmodule : arb_rr_pick
`default_nettype wire

// File: rtl/param_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : param_arbiter
//  Brief   : N-requester arbiter with fixed-priority or round-robin
//            selection, per-requester starvation aging and registered
//            one-hot grants. Optional grant time limit under the macro
//            ARB_TIMEOUT_EN (grant force-released after MAX_HOLD cycles).
//  Ports   : Clock  - rising-edge clock
//            Resetn - asynchronous active-low reset
//            bus    - param_arbiter_if.slave (req in; gnt, gnt_idx, busy,
//                     starved, timeout out)
//  Params  : N (2..16), MODE (0 fixed, 1 round-robin),
//            STARVE_LIMIT (1..15), MAX_HOLD (timeout build only)
//  Revision: 1.0 - initial release
// ============================================================================
module param_arbiter
    import arb_pkg::*;
#(
    parameter int N            = 4,
    parameter int MODE         = 0,
    parameter int STARVE_LIMIT = 3,
    parameter int MAX_HOLD     = 8
) (
    input  logic           Clock,
    input  logic           Resetn,
    param_arbiter_if.slave bus
);

    localparam int c_iw = idx_w(N);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic [N-1:0]      r_gnt;
    logic [c_iw-1:0]   r_gnt_idx;
    logic              r_busy;
    logic              r_timeout;
    logic [c_iw-1:0]   r_last;
    logic [c_cnt_w-1:0] r_cnt [N];

    logic [N-1:0]      w_gnt_d;
    logic [c_iw-1:0]   w_gnt_idx_d;
    logic              w_busy_d;
    logic              w_timeout_d;

    logic [N-1:0]      w_starved;
    logic [N-1:0]      w_elig;
    logic [c_iw-1:0]   w_base;
    logic              w_owner_req;
    logic              w_release;
    logic              w_expire;
    logic              w_take;

    logic [N-1:0]      w_s_oh;
    logic [c_iw-1:0]   w_s_idx;
    logic              w_s_valid;
    logic [N-1:0]      w_p_oh;
    logic [c_iw-1:0]   w_p_idx;
    logic              w_p_valid;
    logic [N-1:0]      w_pick_oh;
    logic [c_iw-1:0]   w_pick_idx;
    logic              w_pick_valid;

    // ------------------------------------------------------------------
    // Starvation flags come straight from the saturated wait counters
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_starved[i] = (r_cnt[i] == c_cnt_w'(STARVE_LIMIT));
        end
    end

    assign w_owner_req = bus.req[r_gnt_idx];
    assign w_release   = (r_state == GRANT) && !w_owner_req;

`ifdef ARB_TIMEOUT_EN
    localparam int c_hw = $clog2(MAX_HOLD + 1);

    logic [c_hw-1:0] r_hold;
    logic            r_excl_vld;
    logic [c_iw-1:0] r_excl_idx;
    logic [N-1:0]    w_excl_oh;
    logic [N-1:0]    w_others;

    // A normal release (owner dropped req) takes precedence over expiry
    assign w_expire = (r_state == GRANT) && w_owner_req &&
                      (r_hold == c_hw'(MAX_HOLD));

    // The expired owner sits out the next pick unless it is alone
    assign w_excl_oh = r_excl_vld ? (N'(1) << r_excl_idx) : '0;
    assign w_others  = bus.req & ~w_excl_oh;
    assign w_elig    = (|w_others) ? w_others : bus.req;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_hold     <= '0;
            r_excl_vld <= 1'b0;
            r_excl_idx <= '0;
        end else begin
            if (w_take) begin
                r_hold     <= c_hw'(1);
                r_excl_vld <= 1'b0;
            end else if (w_expire) begin
                r_hold     <= '0;
                r_excl_vld <= 1'b1;
                r_excl_idx <= r_gnt_idx;
            end else if ((r_state == GRANT) && !w_release) begin
                r_hold <= r_hold + 1'b1;
            end else begin
                r_hold <= '0;
            end
        end
    end
`else
    // Grants are held indefinitely; MAX_HOLD is referenced only so the
    // parameter stays part of the module interface in this build.
    assign w_expire = 1'b0 && (MAX_HOLD != 0);
    assign w_elig   = bus.req;
`endif

    // ------------------------------------------------------------------
    // Winner selection: starved requesters first (lowest index), then the
    // mode-dependent pick over all eligible requests.
    // ------------------------------------------------------------------
    always_comb begin
        w_base = '0;
        if (MODE == MODE_RR) begin
            w_base = (r_last == c_iw'(N - 1)) ? '0 : r_last + 1'b1;
        end
    end

    arb_rr_pick #(
        .N  (N),
        .IW (c_iw)
    ) u_pick_starved (
        .i_mask   (w_elig & w_starved),
        .i_base   ('0),
        .o_onehot (w_s_oh),
        .o_idx    (w_s_idx),
        .o_valid  (w_s_valid)
    );

    arb_rr_pick #(
        .N  (N),
        .IW (c_iw)
    ) u_pick_req (
        .i_mask   (w_elig),
        .i_base   (w_base),
        .o_onehot (w_p_oh),
        .o_idx    (w_p_idx),
        .o_valid  (w_p_valid)
    );

    assign w_pick_valid = w_p_valid;
    assign w_pick_oh    = w_s_valid ? w_s_oh  : w_p_oh;
    assign w_pick_idx   = w_s_valid ? w_s_idx : w_p_idx;
    assign w_take       = (r_state == IDLE) && w_pick_valid;

    // ------------------------------------------------------------------
    // FSM: state/output register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_gnt     <= w_gnt_d;
            r_gnt_idx <= w_gnt_idx_d;
            r_busy    <= w_busy_d;
            r_timeout <= w_timeout_d;
        end
    end

    // FSM: next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_pick_valid)           w_next_state = GRANT;
            GRANT:   if (w_release || w_expire)  w_next_state = IDLE;
            default:                             w_next_state = IDLE;
        endcase
    end

    // FSM: next registered outputs. Leaving GRANT always passes through
    // IDLE, which produces the one dead cycle with gnt=0.
    always_comb begin
        w_gnt_d     = r_gnt;
        w_gnt_idx_d = r_gnt_idx;
        w_busy_d    = r_busy;
        w_timeout_d = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_gnt_d     = w_pick_oh;
                    w_gnt_idx_d = w_pick_idx;
                    w_busy_d    = 1'b1;
                end else begin
                    w_gnt_d  = '0;
                    w_busy_d = 1'b0;
                end
            end
            GRANT: begin
                if (w_release || w_expire) begin
                    w_gnt_d     = '0;
                    w_busy_d    = 1'b0;
                    w_timeout_d = w_expire;
                end
            end
            default: begin
                w_gnt_d  = '0;
                w_busy_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Wait counters and last-grant pointer
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!bus.req[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_take) begin
                    if (w_pick_idx == c_iw'(i)) begin
                        r_cnt[i] <= '0;
                    end else if (r_cnt[i] < c_cnt_w'(STARVE_LIMIT)) begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Reset to N-1 so the first round-robin pick starts at index 0
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_last <= c_iw'(N - 1);
        end else if (w_take) begin
            r_last <= w_pick_idx;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.gnt     = r_gnt;
    assign bus.gnt_idx = r_gnt_idx;
    assign bus.busy    = r_busy;
    assign bus.starved = w_starved;
    assign bus.timeout = r_timeout;

endmodule : param_arbiter
`default_nettype wire

// File: tb/tb_param_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_param_arbiter
//  Brief   : Directed self-checking bench for param_arbiter. One fixed-
//            priority instance and one round-robin instance share the clock
//            and reset. Grant time-limit checks follow ARB_TIMEOUT_EN.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_param_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    param_arbiter_if #(.N(4)) fx_if ();
    param_arbiter_if #(.N(4)) rr_if ();

    param_arbiter #(
        .N            (4),
        .MODE         (0),
        .STARVE_LIMIT (2),
        .MAX_HOLD     (4)
    ) u_fixed (
        .Clock  (clk),
        .Resetn (rst_n),
        .bus    (fx_if)
    );

    // Aging limit of 3 keeps starvation promotion in step with rotation
    // for the all-requesting rotation sequence below.
    param_arbiter #(
        .N            (4),
        .MODE         (1),
        .STARVE_LIMIT (3),
        .MAX_HOLD     (4)
    ) u_rr (
        .Clock  (clk),
        .Resetn (rst_n),
        .bus    (rr_if)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] rr_seq [5];

    initial begin
        rr_seq[0] = 4'b0001;
        rr_seq[1] = 4'b0010;
        rr_seq[2] = 4'b0100;
        rr_seq[3] = 4'b1000;
        rr_seq[4] = 4'b0001;

        // 1. Reset with all requests high
        fx_if.req = 4'b1111;
        rr_if.req = 4'b1111;
        repeat (3) step();
        chk("rst gnt",     32'(fx_if.gnt),     32'h0);
        chk("rst busy",    32'(fx_if.busy),    32'h0);
        chk("rst starved", 32'(fx_if.starved), 32'h0);
        chk("rst timeout", 32'(fx_if.timeout), 32'h0);
        chk("rst rr gnt",  32'(rr_if.gnt),     32'h0);
        fx_if.req = 4'b0000;
        rr_if.req = 4'b0000;
        rst_n     = 1'b1;
        step();
        chk("idle gnt", 32'(fx_if.gnt), 32'h0);

        // 2. Fixed priority, lowest index wins, dead cycle on release
        fx_if.req = 4'b0110;
        step();
        chk("fx first gnt", 32'(fx_if.gnt),     32'b0010);
        chk("fx first idx", 32'(fx_if.gnt_idx), 32'd1);
        chk("fx busy",      32'(fx_if.busy),    32'h1);
        fx_if.req = 4'b0100;
        step();
        chk("fx dead gnt",  32'(fx_if.gnt),  32'b0000);
        chk("fx dead busy", 32'(fx_if.busy), 32'h0);
        step();
        chk("fx second gnt", 32'(fx_if.gnt),     32'b0100);
        chk("fx second idx", 32'(fx_if.gnt_idx), 32'd2);
        fx_if.req = 4'b0000;
        step();
        step();

        // 3. Starvation promotion of req[3] over req[0]
        fx_if.req = 4'b1001;
        step();
        chk("starve win0 a", 32'(fx_if.gnt),     32'b0001);
        chk("starve cnt1",   32'(fx_if.starved), 32'b0000);
        fx_if.req = 4'b1000;
        step();
        chk("starve dead a", 32'(fx_if.gnt), 32'b0000);
        fx_if.req = 4'b1001;
        step();
        chk("starve win0 b", 32'(fx_if.gnt),     32'b0001);
        chk("starved set",   32'(fx_if.starved), 32'b1000);
        fx_if.req = 4'b1000;
        step();
        chk("starve dead b", 32'(fx_if.gnt),     32'b0000);
        chk("starved held",  32'(fx_if.starved), 32'b1000);
        fx_if.req = 4'b1001;
        step();
        chk("starve promote", 32'(fx_if.gnt),     32'b1000);
        chk("starved clear",  32'(fx_if.starved), 32'b0000);
        fx_if.req = 4'b0000;
        step();
        step();

        // 5. Grant time limit (or indefinite hold when the limit is off)
        fx_if.req = 4'b0011;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("hold gnt", 32'(fx_if.gnt),     32'b0001);
            chk("hold to",  32'(fx_if.timeout), 32'h0);
        end
        step();
`ifdef ARB_TIMEOUT_EN
        chk("expire gnt", 32'(fx_if.gnt),     32'b0000);
        chk("expire to",  32'(fx_if.timeout), 32'h1);
        step();
        chk("after expire gnt", 32'(fx_if.gnt),     32'b0010);
        chk("after expire to",  32'(fx_if.timeout), 32'h0);
`else
        chk("no limit gnt", 32'(fx_if.gnt),     32'b0001);
        chk("no limit to",  32'(fx_if.timeout), 32'h0);
        step();
        chk("no limit gnt2", 32'(fx_if.gnt), 32'b0001);
`endif
        fx_if.req = 4'b0000;
        step();
        step();

        // 4. Round-robin rotation with one-cycle grants
        rr_if.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr gnt", 32'(rr_if.gnt), 32'(rr_seq[k]));
            rr_if.req = 4'b1111 & ~rr_seq[k];
            step();
            chk("rr dead", 32'(rr_if.gnt), 32'h0);
            rr_if.req = 4'b1111;
        end
        rr_if.req = 4'b0000;
        step();
        step();

        // 6. Asynchronous reset during a grant
        rr_if.req = 4'b0100;
        step();
        chk("pre-rst gnt", 32'(rr_if.gnt), 32'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst gnt",  32'(rr_if.gnt),  32'h0);
        chk("async rst busy", 32'(rr_if.busy), 32'h0);
        step();
        rr_if.req = 4'b1111;
        rst_n     = 1'b1;
        step();
        chk("post-rst gnt", 32'(rr_if.gnt),     32'b0001);
        chk("post-rst idx", 32'(rr_if.gnt_idx), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_param_arbiter
`default_nettype wire
